// File: rtl/dsp_pkg.sv
// Shared definitions for the decimator: register offsets,
// CTRL bit positions and the default decimation exponent limit.
package dsp_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_LOG2N  = 8'h01;
    localparam logic [7:0] REG_STATUS = 8'h02;
    localparam logic [7:0] REG_OUTCNT = 8'h03;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_BYPASS = 1;

    localparam int LOG2N_MAX_DEF = 8;

endpackage

// File: rtl/dsp_decim_regs.sv
// Register file for dsp_decim: decode, readback, OUTCNT and sticky SAT.
// Ports: fx_* bus + dev_id in; en/bypass/log2n/cfg_wr out; out_pulse and
// sat_set are events from the datapath; fx_q is registered read data.
module dsp_decim_regs
    import dsp_pkg::*;
#(
    parameter int LOG2N_MAX = LOG2N_MAX_DEF
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        fx_wr,
    input  logic [21:0] fx_waddr,
    input  logic [7:0]  fx_data,
    input  logic        fx_rd,
    input  logic [21:0] fx_raddr,
    input  logic [5:0]  dev_id,
    input  logic        out_pulse,
    input  logic        sat_set,
    output logic        en,
    output logic        bypass,
    output logic [3:0]  log2n,
    output logic        cfg_wr,
    output logic [7:0]  fx_q
);

    logic       wr_hit;
    logic       rd_hit;
    logic [7:0] wr_off;
    logic [7:0] rdata;
    logic [3:0] log2n_in;
    logic [7:0] outcnt;
    logic       sat;
    logic       unused_addr;

    assign wr_hit = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rd_hit = fx_raddr[21:16] == dev_id;
    assign wr_off = fx_waddr[7:0];
    assign cfg_wr = wr_hit && (wr_off == REG_CTRL || wr_off == REG_LOG2N);
    assign unused_addr = ^{fx_waddr[15:8], fx_raddr[15:8]};

    // Out-of-range exponents are clamped rather than ignored.
    assign log2n_in = (fx_data > 8'(LOG2N_MAX)) ? 4'(LOG2N_MAX)
                                                : fx_data[3:0];

    always_comb begin
        rdata = 8'h00;
        case (fx_raddr[7:0])
            REG_CTRL:   rdata = {6'b0, bypass, en};
            REG_LOG2N:  rdata = {4'b0, log2n};
            REG_STATUS: rdata = {7'b0, sat};
            REG_OUTCNT: rdata = outcnt;
            default:    rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            bypass <= 1'b0;
            log2n  <= 4'd0;
            sat    <= 1'b0;
            outcnt <= 8'd0;
            fx_q   <= 8'h00;
        end else begin
            if (wr_hit && wr_off == REG_CTRL) begin
                en     <= fx_data[CTRL_EN];
                bypass <= fx_data[CTRL_BYPASS];
            end
            if (wr_hit && wr_off == REG_LOG2N)
                log2n <= log2n_in;
            // A new saturation event wins over a simultaneous clear.
            if (sat_set)
                sat <= 1'b1;
            else if (wr_hit && wr_off == REG_STATUS)
                sat <= 1'b0;
            if (out_pulse)
                outcnt <= outcnt + 8'd1;
            if (fx_rd)
                fx_q <= rd_hit ? rdata : 8'h00;
        end
    end

endmodule

// File: rtl/dsp_decim.sv
// Decimate-by-2^LOG2N averaging filter with bypass and register access.
// Ports: clk_sys/rst_n; ad_data/ad_vld in; sm_data/sm_vld out; fx_* bus.
// Option: define DSP_DECIM_ROUND_EN for rounding with saturation.
module dsp_decim
    import dsp_pkg::*;
#(
    parameter int DW        = 16,
    parameter int LOG2N_MAX = LOG2N_MAX_DEF,
    parameter int ACC_W     = DW + LOG2N_MAX
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [DW-1:0] ad_data,
    input  logic          ad_vld,
    output logic [DW-1:0] sm_data,
    output logic          sm_vld,
    input  logic          fx_wr,
    input  logic [21:0]   fx_waddr,
    input  logic [7:0]    fx_data,
    input  logic          fx_rd,
    input  logic [21:0]   fx_raddr,
    output logic [7:0]    fx_q,
    input  logic [5:0]    dev_id
);

    localparam int CW = LOG2N_MAX + 1;

    logic                    en;
    logic                    bypass;
    logic [3:0]              log2n;
    logic                    cfg_wr;
    logic                    done;
    logic                    out_pulse;
    logic                    sat_set;
    logic signed [ACC_W-1:0] acc;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           last;
    logic signed [ACC_W:0]   sum;
    logic [DW-1:0]           result;

    dsp_decim_regs #(
        .LOG2N_MAX(LOG2N_MAX)
    ) u_regs (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .dev_id   (dev_id),
        .out_pulse(out_pulse),
        .sat_set  (sat_set),
        .en       (en),
        .bypass   (bypass),
        .log2n    (log2n),
        .cfg_wr   (cfg_wr),
        .fx_q     (fx_q)
    );

    // Running total including the sample arriving this cycle.
    assign sum = {acc[ACC_W-1], acc}
               + {{(ACC_W + 1 - DW){ad_data[DW-1]}}, ad_data};

    assign last      = (CW'(1) << log2n) - CW'(1);
    assign done      = en && !bypass && ad_vld && (cnt == last);
    assign out_pulse = done || (en && bypass && ad_vld);

`ifdef DSP_DECIM_ROUND_EN
    localparam logic signed [ACC_W:0] DMAX =
        (ACC_W + 1)'((1 << (DW - 1)) - 1);

    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] lim;
    logic                  over;

    // Overflow is judged on the exact rounded quotient, before the
    // fractional bits are dropped, so a mean of full-scale samples
    // that rounds upward still flags SAT.
    always_comb begin
        bias = '0;
        if (log2n != 4'd0)
            bias = (ACC_W + 1)'(1) <<< (log2n - 4'd1);
        biased = sum + bias;
        lim    = DMAX <<< log2n;
        over   = biased > lim;
    end

    assign result  = over ? DMAX[DW-1:0] : DW'(biased >>> log2n);
    assign sat_set = done && over;
`else
    assign result  = DW'(sum >>> log2n);
    assign sat_set = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sm_data <= '0;
            sm_vld  <= 1'b0;
        end else if (!en) begin
            acc    <= '0;
            cnt    <= '0;
            sm_vld <= 1'b0;
        end else if (bypass) begin
            acc     <= '0;
            cnt     <= '0;
            sm_data <= ad_data;
            sm_vld  <= ad_vld;
        end else begin
            sm_vld <= done;
            if (done)
                sm_data <= result;
            // A completing sample is emitted even under a config write;
            // otherwise the write discards the partial block.
            if (done || cfg_wr) begin
                acc <= '0;
                cnt <= '0;
            end else if (ad_vld) begin
                acc <= sum[ACC_W-1:0];
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dsp_decim.sv
// Randomized self-checking bench for dsp_decim against a queue-based
// block-average reference model.
module tb_dsp_decim;

    localparam logic [5:0] DEV = 6'h15;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic [15:0] ad_data = '0;
    logic        ad_vld  = 1'b0;
    logic [15:0] sm_data;
    logic        sm_vld;
    logic        fx_wr    = 1'b0;
    logic [21:0] fx_waddr = '0;
    logic [7:0]  fx_data  = '0;
    logic        fx_rd    = 1'b0;
    logic [21:0] fx_raddr = '0;
    logic [7:0]  fx_q;
    logic [5:0]  dev_id   = DEV;

    dsp_decim dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .ad_data (ad_data),
        .ad_vld  (ad_vld),
        .sm_data (sm_data),
        .sm_vld  (sm_vld),
        .fx_wr   (fx_wr),
        .fx_waddr(fx_waddr),
        .fx_data (fx_data),
        .fx_rd   (fx_rd),
        .fx_raddr(fx_raddr),
        .fx_q    (fx_q),
        .dev_id  (dev_id)
    );

    always #5 clk_sys = ~clk_sys;

    int errs   = 0;
    int checks = 0;

    // Reference model state
    bit         m_en;
    bit         m_byp;
    bit         m_sat;
    int         m_n;
    int         m_outcnt;
    logic [7:0] m_q;
    int         blk[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int regval(input logic [7:0] off);
        case (off)
            8'h00:   return {m_byp, m_en};
            8'h01:   return m_n;
            8'h02:   return int'(m_sat);
            8'h03:   return m_outcnt;
            default: return 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_en = 0; m_byp = 0; m_sat = 0; m_n = 0;
        m_outcnt = 0; m_q = 8'h00;
        blk.delete();
    endfunction

    task automatic cyc(input bit wr, input bit wok, input logic [7:0] woff,
                       input logic [7:0] wdat, input bit rd, input bit rok,
                       input logic [7:0] roff, input bit vld,
                       input logic [15:0] d);
        bit          ev;
        bit          sset;
        bit          cfg;
        bit          whit;
        logic [15:0] ed;
        longint      s;
        @(negedge clk_sys);
        fx_wr    = wr;
        fx_waddr = {wok ? DEV : ~DEV, 8'h00, woff};
        fx_data  = wdat;
        fx_rd    = rd;
        fx_raddr = {rok ? DEV : ~DEV, 8'h00, roff};
        ad_vld   = vld;
        ad_data  = d;

        ev = 0; ed = '0; sset = 0;
        whit = wr && wok;
        cfg  = whit && (woff == 8'h00 || woff == 8'h01);
        if (rd)
            m_q = rok ? 8'(regval(roff)) : 8'h00;
        if (m_en && m_byp) begin
            ev = vld; ed = d;
            blk.delete();
        end else if (m_en) begin
            if (vld)
                blk.push_back(int'($signed(d)));
            if (blk.size() == (1 << m_n)) begin
                ev = 1;
                s = 0;
                foreach (blk[i]) s += blk[i];
`ifdef DSP_DECIM_ROUND_EN
                if (m_n > 0) s += longint'(1) << (m_n - 1);
                if (s > 32767 * (longint'(1) << m_n)) begin
                    s = 32767 * (longint'(1) << m_n);
                    sset = 1;
                end
`endif
                s = s >>> m_n;
                ed = 16'(s);
                blk.delete();
            end else if (cfg) begin
                blk.delete();
            end
        end else begin
            blk.delete();
        end
        if (ev) m_outcnt = (m_outcnt + 1) % 256;
        if (sset) m_sat = 1;
        else if (whit && woff == 8'h02) m_sat = 0;
        if (whit && woff == 8'h00) begin
            m_en = wdat[0]; m_byp = wdat[1];
        end
        if (whit && woff == 8'h01)
            m_n = (wdat > 8) ? 8 : int'(wdat);

        @(posedge clk_sys);
        #1;
        chk("sm_vld", 32'(sm_vld), 32'(ev));
        if (ev) chk("sm_data", 32'(sm_data), 32'(ed));
        chk("fx_q", 32'(fx_q), 32'(m_q));
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, 0, 1, 0, 0, '0);
    endtask

    task automatic smp(input logic [15:0] d);
        cyc(0, 1, 0, 0, 0, 1, 0, 1, d);
    endtask

    task automatic wreg(input logic [7:0] off, input logic [7:0] dat);
        cyc(1, 1, off, dat, 0, 1, 0, 0, '0);
    endtask

    task automatic rreg(input logic [7:0] off);
        cyc(0, 1, 0, 0, 1, 1, off, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        rst_n = 0; ad_vld = 0; fx_wr = 0; fx_rd = 0;
        model_reset();
        repeat (2) begin
            @(posedge clk_sys);
            #1;
            chk("rst_sm_vld", 32'(sm_vld), 0);
            chk("rst_sm_data", 32'(sm_data), 0);
            chk("rst_fx_q", 32'(fx_q), 0);
        end
        @(negedge clk_sys);
        rst_n = 1;
    endtask

    initial begin
        logic [7:0] wd;
        int r;
        model_reset();
        do_reset();

        for (int i = 0; i < 4; i++) rreg(8'(i));

        wreg(8'h01, 8'd2);
        wreg(8'h00, 8'h01);
        smp(16'd100); smp(16'd200); smp(16'd300); smp(16'd401);
        chk("avg250", 32'(sm_data), 32'd250);
        idle();
        rreg(8'h03);
        chk("outcnt1", 32'(fx_q), 32'd1);

        smp(16'hFFFF); smp(16'hFFFF); smp(16'hFFFF); smp(16'hFFFE);
`ifdef DSP_DECIM_ROUND_EN
        chk("neg_round", 32'(sm_data), 32'h0000FFFF);
`else
        chk("neg_trunc", 32'(sm_data), 32'h0000FFFE);
`endif

        wreg(8'h01, 8'd1);
        smp(16'h7FFF); smp(16'h7FFF);
        chk("fullscale", 32'(sm_data), 32'h7FFF);
        rreg(8'h02);
        wreg(8'h02, 8'h00);
        rreg(8'h02);
        chk("sat_clr", 32'(fx_q), 0);

        wreg(8'h01, 8'd3);
        for (int i = 0; i < 5; i++) smp(16'd1000);
        wreg(8'h00, 8'h01);
        for (int i = 0; i < 8; i++) smp(16'd8);
        chk("avg8", 32'(sm_data), 32'd8);

        wreg(8'h01, 8'hF0);
        rreg(8'h01);
        chk("clamp", 32'(fx_q), 32'd8);
        cyc(1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, '0);
        rreg(8'h00);

        wreg(8'h01, 8'd1);
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                wd = ($urandom_range(0, 5) == 0) ? 8'h03 : 8'h01;
                if ($urandom_range(0, 9) == 0) wd = 8'h00;
                cyc(1, 1, 8'h00, wd, 0, 1, 0,
                    1'($urandom_range(0, 1)), 16'($urandom));
            end else if (r < 6) begin
                wd = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                                 : 8'($urandom_range(0, 4));
                cyc(1, 1, 8'h01, wd, 0, 1, 0,
                    1'($urandom_range(0, 1)), 16'($urandom));
            end else begin
                cyc(r == 6, 1, 8'h02, 8'h00, r < 20,
                    $urandom_range(0, 9) != 0, 8'($urandom_range(0, 5)),
                    $urandom_range(0, 9) < 7, 16'($urandom));
            end
        end

        do_reset();
        wreg(8'h00, 8'h03);
        for (int i = 0; i < 300; i++) smp(16'($urandom));
        idle();
        rreg(8'h03);
        chk("outcnt300", 32'(fx_q), 32'd44);

        wreg(8'h00, 8'h00);
        wreg(8'h01, 8'd2);
        wreg(8'h00, 8'h01);
        smp(16'd50); smp(16'd60);
        do_reset();
        wreg(8'h01, 8'd2);
        wreg(8'h00, 8'h01);
        smp(16'd4); smp(16'd8); smp(16'd12);
        chk("no_early", 32'(sm_vld), 0);
        smp(16'd16);
        chk("post_rst", 32'(sm_data), 32'd10);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dsp_decim.md
DSP_DECIM -- requirements
Module: dsp_decim

Interface
REQ-001 SHALL have parameter DW, default 16: sample width, two's complement, on ad_data and sm_data.
REQ-002 SHALL have parameter LOG2N_MAX, default 8: largest decimation exponent.
REQ-003 SHALL have parameter ACC_W, default DW+LOG2N_MAX: accumulator width.
REQ-004 Port clk_sys, input, 1: the single clock; all logic is rising-edge clk_sys.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port ad_data, input, DW: input sample.
REQ-007 Port ad_vld, input, 1: ad_data valid this cycle; no backpressure.
REQ-008 Port sm_data, output, DW: decimated sample.
REQ-009 Port sm_vld, output, 1: single-cycle valid pulse for sm_data.
REQ-010 Port fx_wr, input, 1, with fx_waddr, input, 22, and fx_data, input, 8: register write strobe, address and data.
REQ-011 Port fx_rd, input, 1, with fx_raddr, input, 22: register read strobe and address.
REQ-012 Port fx_q, output, 8: register read data.
REQ-013 Port dev_id, input, 6: block select; an access addresses this block when addr[21:16]==dev_id, and addr[7:0] is the register offset.

Function
REQ-014 Registers SHALL be:
- 0x00 CTRL, RW: bit0 EN, bit1 BYPASS.
- 0x01 LOG2N, RW, 4 bits: writes above LOG2N_MAX are stored as LOG2N_MAX.
- 0x02 STATUS, RO: bit0 SAT, sticky; writing any value to 0x02 clears it.
- 0x03 OUTCNT, RO, 8 bits: count of sm_vld pulses, wrapping 255->0.
REQ-015 fx_q SHALL be registered: valid the cycle after fx_rd; 0x00 for unmapped offsets or a dev_id mismatch; held at its last value when fx_rd is low.
REQ-016 With EN=1 and BYPASS=0, each ad_vld SHALL add sign-extended ad_data into the accumulator and increment the counter.
REQ-017 On the ad_vld that completes 2^LOG2N samples, the block SHALL:
- load the result, acc_total >>> LOG2N (arithmetic shift, truncated), into sm_data;
- pulse sm_vld for one cycle in the next cycle, so latency is 1 clk_sys;
- clear the accumulator and counter in the same edge, so a back-to-back ad_vld starts the next block with no lost sample.
REQ-018 With LOG2N=0, every ad_vld SHALL produce sm_vld one cycle later with sm_data=ad_data.
REQ-019 With BYPASS=1 and EN=1, sm_data and sm_vld SHALL be ad_data and ad_vld delayed by one register, and the accumulator SHALL be held cleared.
REQ-020 With EN=0, sm_vld SHALL be 0, sm_data SHALL hold its value, and the accumulator and counter SHALL be cleared.
REQ-021 A write to CTRL or LOG2N SHALL clear the accumulator and counter in the same edge; an ad_vld in that same cycle is discarded.
REQ-022 A register write and an ad_vld completing a block in the same cycle SHALL still emit that block's output; the clear then applies.
REQ-023 OUTCNT SHALL increment on every sm_vld, in both bypass and decimating modes.
REQ-024 The accumulator SHALL never wrap: ACC_W covers 2^LOG2N_MAX full-scale samples.

Reset
REQ-025 While rst_n=0, the block SHALL hold:
- sm_data=0, sm_vld=0, fx_q=0;
- CTRL=0x00, LOG2N=0, SAT=0, OUTCNT=0;
- accumulator and counter at 0.
REQ-026 rst_n asserted mid-block SHALL discard the partial sum; after release, no sm_vld occurs until a full new block completes.

Configuration
REQ-027 With macro DSP_DECIM_ROUND_EN defined, the result SHALL be (acc_total + 2^(LOG2N-1)) >>> LOG2N, with no bias added when LOG2N=0.
REQ-028 With DSP_DECIM_ROUND_EN defined, results above the DW maximum SHALL saturate to it and set SAT.
REQ-029 With DSP_DECIM_ROUND_EN undefined, the block SHALL truncate per REQ-017, SAT SHALL read 0, and no rounding or saturation logic SHALL be built.

Structure
REQ-030 Shared package dsp_pkg SHALL hold the register offsets (0x00-0x03), the CTRL bit positions and the default LOG2N_MAX.
REQ-031 Register decode, readback and OUTCNT SHALL live in sub-module dsp_decim_regs; the datapath stays in dsp_decim.

Verification
REQ-032 Bench SHALL cover: reset, then read 0x00-0x03 -> fx_q=0x00 each, one cycle after fx_rd.
REQ-033 Bench SHALL cover: EN=1, LOG2N=2, samples 100,200,300,401 back-to-back -> one sm_vld, the cycle after the 4th ad_vld, with sm_data=250; OUTCNT=1.
REQ-034 Bench SHALL cover: LOG2N=2, samples -1,-1,-1,-2 -> sm_data=-2 when truncating; with DSP_DECIM_ROUND_EN, sm_data=-1.
REQ-035 Bench SHALL cover: DSP_DECIM_ROUND_EN, LOG2N=1, samples 0x7FFF,0x7FFF -> sm_data=0x7FFF and SAT=1; a write to 0x02 then reads SAT=0.
REQ-036 Bench SHALL cover: LOG2N=3, write CTRL after 5 samples, then 8 samples of 8 -> one sm_vld with sm_data=8; the first 5 samples contribute nothing.
REQ-037 Bench SHALL cover: BYPASS=1, 300 samples -> each appears one cycle later on sm_data; OUTCNT=44 (300 mod 256).
